// File: rtl/sensor_filter.sv
// Two-channel moving-average filter (window 2^LOG2_WIN) for cry volume and heart rate; 1-cycle latency, no backpressure.
// Optional outlier rejection of 0x00/0xFF samples is compiled in with SENSOR_OUTLIER_REJECT_EN.
module sensor_filter #(
    parameter int LOG2_WIN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rawHuil,
    input  logic [7:0] rawHart,
    input  logic       sampleValid,
    output logic [7:0] huilVolume,
    output logic [7:0] hartRitme,
    output logic       filtValid,
    output logic       newSample,
    output logic [3:0] faultCnt
);

    localparam int N  = 1 << LOG2_WIN;
    localparam int SW = 8 + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] PTR_ONE = 1;
    localparam logic [LOG2_WIN:0]   CNT_ONE = 1;

    logic [7:0]          huil_buf_q [N];
    logic [7:0]          hart_buf_q [N];
    logic [SW-1:0]       huil_sum_q, huil_sum_d;
    logic [SW-1:0]       hart_sum_q, hart_sum_d;
    logic [LOG2_WIN-1:0] ptr_q;
    logic [LOG2_WIN:0]   cnt_q;
    logic [7:0]          huil_out_q, hart_out_q;
    logic                new_q;
    logic [7:0]          huil_in, hart_in;

`ifdef SENSOR_OUTLIER_REJECT_EN
    logic [7:0] last_huil_q, last_hart_q;
    logic [3:0] fault_q;
    logic       huil_rej, hart_rej;

    always_comb begin
        huil_rej = (rawHuil == 8'h00) || (rawHuil == 8'hFF);
        hart_rej = (rawHart == 8'h00) || (rawHart == 8'hFF);
        huil_in  = huil_rej ? last_huil_q : rawHuil;
        hart_in  = hart_rej ? last_hart_q : rawHart;
    end

    // The substituted value counts as accepted, so it also becomes the new "last" sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_huil_q <= 8'h00;
            last_hart_q <= 8'h00;
            fault_q     <= 4'h0;
        end else if (sampleValid) begin
            last_huil_q <= huil_in;
            last_hart_q <= hart_in;
            if ((huil_rej || hart_rej) && (fault_q != 4'hF))
                fault_q <= fault_q + 4'h1;
        end
    end

    assign faultCnt = fault_q;
`else
    assign huil_in  = rawHuil;
    assign hart_in  = rawHart;
    assign faultCnt = 4'h0;
`endif

    // The outgoing entry is always part of the sum, so the subtraction cannot underflow.
    always_comb begin
        huil_sum_d = huil_sum_q + SW'(huil_in) - SW'(huil_buf_q[ptr_q]);
        hart_sum_d = hart_sum_q + SW'(hart_in) - SW'(hart_buf_q[ptr_q]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                huil_buf_q[i] <= 8'h00;
                hart_buf_q[i] <= 8'h00;
            end
            huil_sum_q <= '0;
            hart_sum_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            huil_out_q <= 8'h00;
            hart_out_q <= 8'h00;
            new_q      <= 1'b0;
        end else begin
            new_q <= sampleValid;
            if (sampleValid) begin
                huil_buf_q[ptr_q] <= huil_in;
                hart_buf_q[ptr_q] <= hart_in;
                huil_sum_q        <= huil_sum_d;
                hart_sum_q        <= hart_sum_d;
                ptr_q             <= ptr_q + PTR_ONE;
                huil_out_q        <= huil_sum_d[SW-1:LOG2_WIN];
                hart_out_q        <= hart_sum_d[SW-1:LOG2_WIN];
                // N is a power of two, so the count is full exactly when its MSB is set.
                if (!cnt_q[LOG2_WIN])
                    cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign huilVolume = huil_out_q;
    assign hartRitme  = hart_out_q;
    assign filtValid  = cnt_q[LOG2_WIN];
    assign newSample  = new_q;

endmodule

// File: tb/tb_sensor_filter.sv
// Bench for sensor_filter: directed vector table, multi-cycle corner sequences, then random traffic vs a window model.
module tb_sensor_filter;

    localparam int LOG2_WIN = 3;
    localparam int N        = 1 << LOG2_WIN;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rawHuil, rawHart;
    logic       sampleValid;
    logic [7:0] huilVolume, hartRitme;
    logic       filtValid, newSample;
    logic [3:0] faultCnt;

    int vectors    = 0;
    int miscompares = 0;

    sensor_filter #(.LOG2_WIN(LOG2_WIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .rawHuil    (rawHuil),
        .rawHart    (rawHart),
        .sampleValid(sampleValid),
        .huilVolume (huilVolume),
        .hartRitme  (hartRitme),
        .filtValid  (filtValid),
        .newSample  (newSample),
        .faultCnt   (faultCnt)
    );

    always #5 clk = ~clk;

    // Reference model: keeps the literal window contents and averages them on demand.
    int win_h [N];
    int win_r [N];
    int m_ptr, m_cnt, m_last_h, m_last_r;
    int m_h, m_r, m_fv, m_ns, m_fault;

    task automatic model(input bit rst, input bit vld, input int h, input int r);
        int ch, cr, sh, sr;
        bit rej;
        if (rst) begin
            for (int i = 0; i < N; i++) begin win_h[i] = 0; win_r[i] = 0; end
            m_ptr = 0; m_cnt = 0; m_last_h = 0; m_last_r = 0;
            m_h = 0; m_r = 0; m_fv = 0; m_ns = 0; m_fault = 0;
        end else if (vld) begin
            ch = h; cr = r; rej = 0;
`ifdef SENSOR_OUTLIER_REJECT_EN
            if (h == 0 || h == 255) begin ch = m_last_h; rej = 1; end
            if (r == 0 || r == 255) begin cr = m_last_r; rej = 1; end
            if (rej && m_fault < 15) m_fault++;
`endif
            m_last_h = ch; m_last_r = cr;
            win_h[m_ptr] = ch; win_r[m_ptr] = cr;
            m_ptr = (m_ptr + 1) % N;
            if (m_cnt < N) m_cnt++;
            sh = 0; sr = 0;
            for (int i = 0; i < N; i++) begin sh += win_h[i]; sr += win_r[i]; end
            m_h = sh / N; m_r = sr / N;
            m_fv = (m_cnt == N) ? 1 : 0;
            m_ns = 1;
        end else begin
            m_ns = 0;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit vld, input int h, input int r);
        reset       = rst;
        sampleValid = vld;
        rawHuil     = 8'(h);
        rawHart     = 8'(r);
        @(posedge clk);
        #1;
        model(rst, vld, h, r);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_huil"},  int'(huilVolume), m_h);
        chk({tag, "_hart"},  int'(hartRitme),  m_r);
        chk({tag, "_fv"},    int'(filtValid),  m_fv);
        chk({tag, "_ns"},    int'(newSample),  m_ns);
        chk({tag, "_fault"}, int'(faultCnt),   m_fault);
    endtask

    typedef struct {
        bit rst, vld;
        int h, r;
        int eh, er, efv, ens;
    } vec_t;

    vec_t tbl [18];

    initial begin
        reset = 1'b1; sampleValid = 1'b0; rawHuil = 8'h00; rawHart = 8'h00;

        // Reset wins over a simultaneous strobe; then a fill at 0x40/0x50, a hold, and a wrap to 0x80.
        tbl[0] = '{1, 1, 'h40, 'h50, 0, 0, 0, 0};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{0, 1, 'h40, 'h50, k * 8, k * 10, (k == 8) ? 1 : 0, 1};
        tbl[9] = '{0, 0, 'h11, 'h22, 'h40, 'h50, 1, 0};
        for (int j = 1; j <= 8; j++)
            tbl[9 + j] = '{0, 1, 'h80, 'h50, 'h40 + 8 * j, 'h50, 1, 1};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].h, tbl[i].r);
            chk($sformatf("tbl%0d_huil", i), int'(huilVolume), tbl[i].eh);
            chk($sformatf("tbl%0d_hart", i), int'(hartRitme),  tbl[i].er);
            chk($sformatf("tbl%0d_fv", i),   int'(filtValid),  tbl[i].efv);
            chk($sformatf("tbl%0d_ns", i),   int'(newSample),  tbl[i].ens);
            chk($sformatf("tbl%0d_fault", i), int'(faultCnt),  0);
        end

        // Sixteen back-to-back strobes alternating 0x10/0x30.
        for (int i = 0; i < 16; i++) begin
            step(0, 1, (i % 2 == 0) ? 'h10 : 'h30, 'h50);
            chk("b2b_ns", int'(newSample), 1);
        end
        chk("b2b_avg", int'(huilVolume), 'h20);

        // Outlier behaviour on a window filled at 0x60.
        for (int i = 0; i < 8; i++) step(0, 1, 'h60, 'h60);
        for (int i = 0; i < 3; i++) step(0, 1, 'hFF, 'h60);
`ifdef SENSOR_OUTLIER_REJECT_EN
        chk("outl_huil", int'(huilVolume), 'h60);
        chk("outl_fault3", int'(faultCnt), 3);
        for (int i = 0; i < 20; i++) step(0, 1, 'hFF, 'h60);
        chk("outl_fault_sat", int'(faultCnt), 15);
`else
        chk("outl_huil", int'(huilVolume), 'h9B);
        chk("outl_fault0", int'(faultCnt), 0);
`endif

        // Reset mid-window together with a strobe, then a fresh fill.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 'h70, 'h30);
        step(1, 1, 'h70, 'h30);
        chk("rst_huil", int'(huilVolume), 0);
        chk("rst_hart", int'(hartRitme), 0);
        chk("rst_fv", int'(filtValid), 0);
        chk("rst_ns", int'(newSample), 0);
        chk("rst_fault", int'(faultCnt), 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 'h70, 'h30);
            chk("refill_fv", int'(filtValid), (i == 8) ? 1 : 0);
        end
        chk("refill_huil", int'(huilVolume), 'h70);

        // Randomised traffic with outlier values and occasional resets.
        for (int i = 0; i < 600; i++) begin
            int h, r;
            bit rst, vld;
            rst = ($urandom_range(0, 59) == 0);
            vld = ($urandom_range(0, 2) != 0);
            h = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 255 : 0) : int'($urandom_range(0, 255));
            r = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 255 : 0) : int'($urandom_range(0, 255));
            step(rst, vld, h, r);
            chk_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
